// File: rtl/rib_arbiter_if.sv
// Requester / RIB handshake bundle for rib_arbiter.
// slave  : the arbiter side (accepts requests, drives the RIB, returns results)
// master : the environment side (requesters plus the RIB unit)
interface rib_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*192-1:0] req_ray;
    logic [N_REQ*192-1:0] req_box;
    logic [N_REQ-1:0]     rsp_valid;
    logic                 rsp_hit;
    logic                 rib_en;
    logic [191:0]         rib_ray;
    logic [191:0]         rib_box;
    logic                 rib_hit;

    modport slave (
        input  req_valid, req_ray, req_box, rib_hit,
        output req_ready, rsp_valid, rsp_hit, rib_en, rib_ray, rib_box
    );

    modport master (
        output req_valid, req_ray, req_box, rib_hit,
        input  req_ready, rsp_valid, rsp_hit, rib_en, rib_ray, rib_box
    );
endinterface

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one pipelined ray_intersect_box unit between
// N_REQ traversal lanes. A tag pipeline matched to RIB_LAT routes each
// hit/miss back to its originator; a per-lane in-flight cap keeps lanes fair.
// Optional feature macro: RIB_ARB_STATS_EN adds saturating grant/hit counters.
module rib_arbiter #(
    parameter int N_REQ    = 4,
    parameter int RIB_LAT  = 8,
    parameter int MAX_OUT  = 4,
    parameter int FRA_BITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rib_arbiter_if.slave       bus
`ifdef RIB_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0] stat_grants,
    output logic [31:0]         stat_hits
`endif
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int ID_W  = 3;

    // Coordinates are opaque here; FRA_BITS only has to be a sane Q-format.
    if (N_REQ < 2 || N_REQ > 8 || RIB_LAT < 1 || MAX_OUT < 1 || MAX_OUT > 15 ||
        FRA_BITS < 0 || FRA_BITS > 31) begin : g_param_check
        $error("rib_arbiter: parameter out of range");
    end

    logic [PTR_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt [N_REQ];
    logic             r_rib_en;
    logic [ID_W-1:0]  r_issue_id;
    logic [191:0]     r_rib_ray;
    logic [191:0]     r_rib_box;
    logic [RIB_LAT:1] r_tag_v;
    logic [ID_W-1:0]  r_tag_id [1:RIB_LAT];
    logic [N_REQ-1:0] r_rsp_valid;
    logic             r_rsp_hit;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic             w_gnt_any;
    logic [PTR_W-1:0] w_gnt_id;
    logic [191:0]     w_sel_ray;
    logic [191:0]     w_sel_box;

    // A lane may compete only while it is below its in-flight cap.
    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            w_elig[r] = bus.req_valid[r] && (r_cnt[r] < CNT_W'(MAX_OUT));
        end
    end

    // Round-robin pick: first eligible lane scanning upward from r_rr_ptr.
    always_comb begin
        int idx;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        idx       = 0;
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % N_REQ;
            if (!w_gnt_any && w_elig[idx]) begin
                w_gnt_any   = 1'b1;
                w_gnt[idx]  = 1'b1;
                w_gnt_id    = PTR_W'(idx);
            end
        end
    end

    // Operands of the granted lane, ready to be registered toward the RIB.
    always_comb begin
        w_sel_ray = bus.req_ray[int'(w_gnt_id)*192 +: 192];
        w_sel_box = bus.req_box[int'(w_gnt_id)*192 +: 192];
    end

    assign bus.req_ready = w_gnt;

    // Issue stage: register the grant into the RIB strobe and advance the pointer.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_rib_en   <= 1'b0;
            r_issue_id <= '0;
            r_rib_ray  <= '0;
            r_rib_box  <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_rib_en <= w_gnt_any;
            if (w_gnt_any) begin
                r_issue_id <= ID_W'(w_gnt_id);
                r_rib_ray  <= w_sel_ray;
                r_rib_box  <= w_sel_box;
                r_rr_ptr   <= (w_gnt_id == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            end
        end
    end

    // Tag valids shadow the RIB pipeline; stage RIB_LAT lines up with rib_hit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_v <= '0;
        end else begin
            r_tag_v <= {r_tag_v[RIB_LAT-1:1], r_rib_en};
        end
    end

    // Tag ids ride alongside the valids.
    always_ff @(posedge i_clk) begin
        // NOTE: the id array has no reset; its contents are only used when the matching valid is set.
        r_tag_id[1] <= r_issue_id;
        for (int k = 2; k <= RIB_LAT; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
        end
    end

    // Return the RIB result to the lane whose tag reached the end of the pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_hit   <= 1'b0;
        end else if (r_tag_v[RIB_LAT]) begin
            r_rsp_valid <= N_REQ'(1) << r_tag_id[RIB_LAT];
            r_rsp_hit   <= bus.rib_hit;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_hit   <= 1'b0;
        end
    end

    // In-flight count per lane: up on handshake, down when its result is delivered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < N_REQ; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < N_REQ; r++) begin
                case ({w_gnt[r], r_rsp_valid[r]})
                    2'b10:   r_cnt[r] <= r_cnt[r] + 1'b1;
                    2'b01:   r_cnt[r] <= r_cnt[r] - 1'b1;
                    default: r_cnt[r] <= r_cnt[r];
                endcase
            end
        end
    end

    assign bus.rib_en    = r_rib_en;
    assign bus.rib_ray   = r_rib_ray;
    assign bus.rib_box   = r_rib_box;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;

`ifdef RIB_ARB_STATS_EN
    logic [31:0] r_stat_grants [N_REQ];
    logic [31:0] r_stat_hits;

    // Saturating per-lane grant counters and a total hit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < N_REQ; r++) r_stat_grants[r] <= '0;
            r_stat_hits <= '0;
        end else begin
            for (int r = 0; r < N_REQ; r++) begin
                if (w_gnt[r] && r_stat_grants[r] != 32'hFFFF_FFFF) begin
                    r_stat_grants[r] <= r_stat_grants[r] + 32'd1;
                end
            end
            if ((|r_rsp_valid) && r_rsp_hit && r_stat_hits != 32'hFFFF_FFFF) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat_out
        assign stat_grants[g*32 +: 32] = r_stat_grants[g];
    end
    assign stat_hits = r_stat_hits;
`endif
endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: a cycle-by-cycle vector table for the
// arbitration/cap behaviour, then hand-written latency, round-robin, cap and
// mid-flight reset sequences. A behavioural RIB stand-in computes hit/miss.
module tb_rib_arbiter;
    localparam int N_REQ   = 4;
    localparam int RIB_LAT = 8;
    localparam int MAX_OUT = 4;
    localparam int LAT     = RIB_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rib_arbiter_if #(.N_REQ(N_REQ)) bus ();

`ifdef RIB_ARB_STATS_EN
    logic [N_REQ*32-1:0] stat_grants;
    logic [31:0]         stat_hits;
`endif

    rib_arbiter #(
        .N_REQ(N_REQ), .RIB_LAT(RIB_LAT), .MAX_OUT(MAX_OUT), .FRA_BITS(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
`ifdef RIB_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_hits(stat_hits)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stand-in RIB: fixed RIB_LAT pipeline. The slab test is exact for rays
    // with at most one non-zero direction component, which is all we use.
    function automatic logic model_hit(input logic [191:0] ray, input logic [191:0] box);
        logic ok;
        logic signed [31:0] o, d, mn, mx;
        ok = 1'b1;
        for (int a = 0; a < 3; a++) begin
            o  = ray[a*32 +: 32];
            d  = ray[96 + a*32 +: 32];
            mn = box[a*32 +: 32];
            mx = box[96 + a*32 +: 32];
            if (d == 0)     ok = ok && (o >= mn) && (o <= mx);
            else if (d > 0) ok = ok && (mx >= o);
            else            ok = ok && (mn <= o);
        end
        return ok;
    endfunction

    logic [RIB_LAT:1] rib_pipe = '0;
    always @(posedge clk) begin
        rib_pipe <= {rib_pipe[RIB_LAT-1:1], bus.rib_en ? model_hit(bus.rib_ray, bus.rib_box) : 1'b0};
    end
    assign bus.rib_hit = rib_pipe[RIB_LAT];

    function automatic logic [95:0] p3(input int x, input int y, input int z);
        return {z[31:0], y[31:0], x[31:0]};
    endfunction

    logic [191:0] ray_x, box_hit, box_miss;

    task automatic set_data(input int r, input logic [191:0] ray, input logic [191:0] box);
        bus.req_ray[r*192 +: 192] = ray;
        bus.req_box[r*192 +: 192] = box;
    endtask

    // Even lanes aim at the hit box, odd lanes at the miss box.
    task automatic set_alternating();
        for (int r = 0; r < N_REQ; r++) set_data(r, ray_x, (r % 2 == 0) ? box_hit : box_miss);
    endtask

    // Called at #1 into the cycle after a handshake; expects one result exactly LAT cycles later.
    task automatic wait_rsp(input logic [3:0] exp_v, input logic exp_h, input string nm);
        int k;
        k = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                k = c;
                break;
            end
        end
        check({nm, " latency"}, 64'(k), 64'(LAT));
        check({nm, " rsp_valid"}, 64'(bus.rsp_valid), 64'(exp_v));
        check({nm, " rsp_hit"}, 64'(bus.rsp_hit), 64'(exp_h));
        @(posedge clk); #1;
    endtask

    task automatic issue_one(input int r, input logic [191:0] box, input logic exp_h, input string nm);
        set_data(r, ray_x, box);
        bus.req_valid = 4'(1 << r);
        @(negedge clk);
        check({nm, " req_ready"}, 64'(bus.req_ready), 64'(1 << r));
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp(4'(1 << r), exp_h, nm);
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic       rib_en;
        logic [3:0] rsp;
        logic       hit;
    } vec_t;

    typedef struct {
        int   id;
        logic hit;
    } exp_t;

    vec_t tbl [13];
    exp_t sb [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g, n_rsp, m;
        logic hs [0:63];
        logic exp_rdy, exp_rsp;
`ifdef RIB_ARB_STATS_EN
        logic [31:0] g0 [N_REQ];
        logic [31:0] h0;
`endif
        ray_x    = {p3(1000, 0, 0), p3(0, 0, 0)};
        box_hit  = {p3(1500, 500, 500), p3(500, -500, -500)};
        box_miss = {p3(1500, 3000, 500), p3(500, 2000, -500)};

        // Cycle-by-cycle table starting right after reset (rr_ptr=0, counts 0).
        // Lane 0 saturates at MAX_OUT and only regains a slot after its first result.
        tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{4'b1001, 4'b1000, 1'b1, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0110, 4'b0010, 1'b1, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0011, 4'b0010, 1'b0, 4'b0000, 1'b0};
        tbl[10] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1};
        tbl[11] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0};
        tbl[12] = '{4'b0001, 4'b0000, 1'b1, 4'b1000, 1'b0};

        bus.req_valid = '0;
        bus.req_ray   = '0;
        bus.req_box   = '0;
        set_alternating();

        // Test 1: reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(bus.req_ready), 64'd0);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("reset rib_en", 64'(bus.rib_en), 64'd0);
        check("reset rib_ray", 64'(|bus.rib_ray), 64'd0);
        check("reset rib_box", 64'(|bus.rib_box), 64'd0);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = tbl[i].valid;
            @(negedge clk);
            check($sformatf("tbl[%0d] req_ready", i), 64'(bus.req_ready), 64'(tbl[i].ready));
            check($sformatf("tbl[%0d] rib_en", i), 64'(bus.rib_en), 64'(tbl[i].rib_en));
            check($sformatf("tbl[%0d] rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].rsp));
            if (tbl[i].rsp != '0)
                check($sformatf("tbl[%0d] rsp_hit", i), 64'(bus.rsp_hit), 64'(tbl[i].hit));
            @(posedge clk); #1;
        end
        idle(LAT + 5);

        // Test 2 / 3: single requests, exact latency and routing.
        issue_one(0, box_hit, 1'b1, "t2 req0 hit");
        issue_one(2, box_miss, 1'b0, "t3 req2 miss");

        // Test 4: all lanes continuously valid for 40 cycles (rr_ptr=3 after test 3).
        set_alternating();
`ifdef RIB_ARB_STATS_EN
        for (int r = 0; r < N_REQ; r++) g0[r] = stat_grants[r*32 +: 32];
        h0 = stat_hits;
`endif
        exp_g = 3;
        n_rsp = 0;
        for (int c = 0; c < 40 + LAT + 2; c++) begin
            bus.req_valid = (c < 40) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 40) begin
                check($sformatf("t4 c%0d grant", c), 64'(bus.req_ready), 64'(1 << exp_g));
                sb.push_back('{exp_g, (exp_g % 2 == 0)});
                exp_g = (exp_g + 1) % N_REQ;
            end
            if (c >= 1 && c <= 40) check($sformatf("t4 c%0d rib_en", c), 64'(bus.rib_en), 64'd1);
            if (bus.rsp_valid != '0) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check($sformatf("t4 c%0d unexpected rsp", c), 64'(bus.rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("t4 c%0d rsp_valid", c), 64'(bus.rsp_valid), 64'(1 << e.id));
                    check($sformatf("t4 c%0d rsp_hit", c), 64'(bus.rsp_hit), 64'(e.hit));
                end
            end
            @(posedge clk); #1;
        end
        check("t4 response count", 64'(n_rsp), 64'd40);
        check("t4 scoreboard empty", 64'(sb.size()), 64'd0);
`ifdef RIB_ARB_STATS_EN
        for (int r = 0; r < N_REQ; r++) begin
            logic [31:0] dg;
            dg = stat_grants[r*32 +: 32] - g0[r];
            check($sformatf("t4 stat_grants[%0d] in 9..11", r), 64'(dg >= 9 && dg <= 11), 64'd1);
        end
        check("t4 stat_hits delta", 64'(stat_hits - h0), 64'd20);
`endif
        idle(2);

        // Test 5: lane 1 alone against the in-flight cap, independent count model.
        set_data(1, ray_x, box_hit);
        m = 0;
        for (int t = 0; t < 30; t++) begin
            bus.req_valid = 4'b0010;
            exp_rdy = (m < MAX_OUT);
            exp_rsp = (t >= LAT) ? hs[t-LAT] : 1'b0;
            @(negedge clk);
            check($sformatf("t5 t%0d req_ready", t), 64'(bus.req_ready), exp_rdy ? 64'h2 : 64'h0);
            check($sformatf("t5 t%0d rsp_valid", t), 64'(bus.rsp_valid), exp_rsp ? 64'h2 : 64'h0);
            if (exp_rsp) check($sformatf("t5 t%0d rsp_hit", t), 64'(bus.rsp_hit), 64'd1);
            hs[t] = exp_rdy;
            m = m + int'(exp_rdy) - int'(exp_rsp);
            @(posedge clk); #1;
        end
        idle(LAT + 5);

        // Test 6: reset with 5 tests in flight; stale RIB results must be dropped.
        set_alternating();
        bus.req_valid = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6 reset rib_en", 64'(bus.rib_en), 64'd0);
        check("t6 reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check($sformatf("t6 quiet c%0d", c), 64'(bus.rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("t6 rr_ptr restart", 64'(bus.req_ready), 64'h1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp(4'b0001, 1'b1, "t6 post-reset req0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
